fsm_1011_bit_serializer: RTL and testbench
==========================================

Name: fsm_1011_bit_serializer

Overview:
- Upstream feeder for the 1011 sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled clock on x, the detector's serial input.
- A one-word holding register lets consecutive words stream with no gap, so sequences spanning word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- bit_en  input  1  shift advance enable (bit strobe).
- x  output  1  serial bit to the detector; registered.
- x_valid  output  1  x carries a real data bit this cycle; registered.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word on x.
- busy  output  1  shifter or holding register occupied.

Behaviour:
- Reset: rst sampled high at a posedge sets the state to IDLE and clears shift_reg, hold_reg, hold_full and bit_cnt.
  - Outputs after reset: x=0, x_valid=0, word_done=0, busy=0, load_ready=1.
  - Reset mid-word discards the word in flight and any held word; no partial bits follow.
- Handshake:
  - accept = load_valid & load_ready, sampled at posedge.
  - load_ready = ~hold_full; it is combinational from registered state only.
  - load_data is ignored when accept is 0.
- States:
  - IDLE: shifter empty, x_valid=0.
  - SHIFT: a word is on x, with bit_cnt counting 0..WIDTH-1.
- IDLE -> SHIFT:
  - On accept, the word loads straight into shift_reg.
  - The first bit appears on x with x_valid=1 the cycle after the accepting edge, so latency is 1 cycle.
  - This load does not wait for bit_en.
- SHIFT:
  - At a posedge with bit_en=1, bit_cnt increments and x takes the next bit.
  - With bit_en=0, x, x_valid and bit_cnt hold, and x_valid stays 1.
  - The detector sees each bit for as many cycles as bit_en stays low.
- Last bit: bit_cnt == WIDTH-1 drives word_done=1 combinationally from state.
  - word_done stays high while the last bit is stalled by bit_en=0.
- Advance past the last bit (bit_en=1 on the last bit):
  - hold_full=1: hold_reg moves to shift_reg, the next word's first bit is on x the next cycle (gapless), and hold_full clears.
  - hold_full=0 and accept this edge: the accepted word loads directly into shift_reg (gapless).
  - Otherwise: go to IDLE with x_valid=0 and x=0.
- Accept while in SHIFT: the word goes to hold_reg and hold_full is set.
  - An accept on the same edge as a hold->shift transfer is impossible, because load_ready was 0 that cycle.
- Bit order:
  - MSB_FIRST=1: shift left and send the MSB.
  - MSB_FIRST=0: shift right and send the LSB.
- busy = (state==SHIFT) | hold_full.
- Words are never dropped or reordered. Output order equals accept order.

Test Plan:
- Reset check: assert rst 2 cycles -> x=0, x_valid=0, word_done=0, busy=0, load_ready=1. Release rst with load_valid=0 for 5 cycles -> outputs unchanged.
- Single word, 1-cycle latency, MSB-first: WIDTH=8, bit_en=1, load 8'hB4 -> x sequence 1,0,1,1,0,1,0,0 starting the cycle after accept. word_done high on the 8th bit only. Downstream detector pulses once, after the 4th bit. x_valid drops after the 8th bit.
- Back-to-back words: load 8'h05 then 8'h6F while the first is still shifting. The second word goes to hold, so load_ready=0 until the transfer. Result: 16 contiguous valid bits 0000_0101_0110_1111 with no gap, and the cross-boundary 1011 is detected.
- Stall: load 8'hFF with bit_en toggling 1,0,0,1,... -> each bit holds while bit_en=0. Exactly 8 advances occur, and word_done stays high throughout the stalled last bit.
- LSB-first: MSB_FIRST=0, load 8'h0D -> x sequence 1,0,1,1,0,0,0,0.
- Reset mid-word: rst asserted on the 3rd bit with hold_full=1 -> next cycle x_valid=0, busy=0, load_ready=1, and no bits from either word appear afterward.

Source files
------------

// File: rtl/fsm_1011_bit_serializer.sv
// ---------------------------------------------------------------------------
// fsm_1011_bit_serializer
//
// Upstream feeder for the 1011 sequence detector. Parallel words arrive over a
// valid/ready handshake and leave one bit per enabled clock on x. A one-word
// holding register lets consecutive words stream with no gap, so a pattern
// that spans a word boundary still reaches the detector intact.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   load_data   parallel word to serialize
//   load_valid  load_data is valid this cycle
//   load_ready  block can accept a word this cycle (holding register empty)
//   bit_en      bit strobe; each high cycle advances x by one bit
//   x           serial bit to the detector (flop output)
//   x_valid     x carries a real data bit this cycle (flop output)
//   word_done   high while the last bit of a word is on x
//   busy        shifter or holding register occupied
// ---------------------------------------------------------------------------
module fsm_1011_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [CW-1:0]    bit_cnt_q;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shift_d;

  // The shifter is cleared whenever the block goes idle, so the outgoing bit
  // can be taken straight from the shift register flop: x is 0 when idle and
  // never depends on combinational input paths.
  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & load_ready;
  assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
  assign shift_d    = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_q[WIDTH-1:1]};

  assign x         = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign x_valid   = (state_q == SHIFT);
  assign word_done = last_bit;
  assign busy      = (state_q == SHIFT) | hold_full_q;

  // Serializer state machine. A word accepted while idle goes directly into
  // the shifter without waiting for bit_en. While shifting, an accepted word
  // parks in the holding register. When the last bit advances, the held word
  // (or, if none, a word accepted on this same edge) takes over the shifter
  // so the bit stream stays contiguous across words. The later hold_full_q
  // assignment in the direct-load path overrides the parking assignment above
  // it, so a word loaded straight into the shifter is never also held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q   <= load_data;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            hold_q      <= load_data;
            hold_full_q <= 1'b1;
          end
          if (bit_en) begin
            if (bit_cnt_q == LAST_IDX) begin
              bit_cnt_q <= '0;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
              end else if (accept) begin
                shift_q     <= load_data;
                hold_full_q <= 1'b0;
              end else begin
                shift_q <= '0;
                state_q <= IDLE;
              end
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_1011_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_fsm_1011_bit_serializer
//
// Drives an MSB-first and an LSB-first serializer from the same stimulus and
// compares both against a word-queue model every cycle, plus directed
// scenarios with literal expected bit streams.
// ---------------------------------------------------------------------------
module tb_fsm_1011_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] loadData;
  logic         loadValid;
  logic         bitEn;

  logic readyM, xM, xvM, doneM, busyM;
  logic readyL, xL, xvL, doneL, busyL;

  int vectors;
  int miscompares;
  bit checkEn;

  fsm_1011_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk       (clk),
    .rst       (rst),
    .load_data (loadData),
    .load_valid(loadValid),
    .load_ready(readyM),
    .bit_en    (bitEn),
    .x         (xM),
    .x_valid   (xvM),
    .word_done (doneM),
    .busy      (busyM)
  );

  fsm_1011_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk       (clk),
    .rst       (rst),
    .load_data (loadData),
    .load_valid(loadValid),
    .load_ready(readyL),
    .bit_en    (bitEn),
    .x         (xL),
    .x_valid   (xvL),
    .word_done (doneL),
    .busy      (busyL)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the word currently on x plus how many of its bits have
  // been sent, and a FIFO of words accepted but not yet started.
  bit           mActive;
  logic [W-1:0] mWord;
  int           mIdx;
  logic [W-1:0] mPend[$];

  always @(posedge clk) begin
    bit acc;
    bit consumed;
    acc      = loadValid && (mPend.size() == 0);
    consumed = 1'b0;
    if (rst) begin
      mActive = 1'b0;
      mIdx    = 0;
      mWord   = '0;
      mPend.delete();
    end else if (!mActive) begin
      if (acc) begin
        mActive = 1'b1;
        mWord   = loadData;
        mIdx    = 0;
      end
    end else begin
      if (bitEn) begin
        if (mIdx == W - 1) begin
          if (mPend.size() > 0) begin
            mWord = mPend.pop_front();
            mIdx  = 0;
          end else if (acc) begin
            mWord    = loadData;
            mIdx     = 0;
            consumed = 1'b1;
          end else begin
            mActive = 1'b0;
          end
        end else begin
          mIdx++;
        end
      end
      if (acc && !consumed) mPend.push_back(loadData);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("x_valid_msb",    {31'd0, xvM},    {31'd0, mActive});
      checkOutput("x_valid_lsb",    {31'd0, xvL},    {31'd0, mActive});
      checkOutput("x_msb",          {31'd0, xM},     {31'd0, mActive ? mWord[W-1-mIdx] : 1'b0});
      checkOutput("x_lsb",          {31'd0, xL},     {31'd0, mActive ? mWord[mIdx] : 1'b0});
      checkOutput("word_done_msb",  {31'd0, doneM},  {31'd0, mActive && (mIdx == W - 1)});
      checkOutput("word_done_lsb",  {31'd0, doneL},  {31'd0, mActive && (mIdx == W - 1)});
      checkOutput("busy_msb",       {31'd0, busyM},  {31'd0, mActive || (mPend.size() > 0)});
      checkOutput("busy_lsb",       {31'd0, busyL},  {31'd0, mActive || (mPend.size() > 0)});
      checkOutput("load_ready_msb", {31'd0, readyM}, {31'd0, mPend.size() == 0});
      checkOutput("load_ready_lsb", {31'd0, readyL}, {31'd0, mPend.size() == 0});
    end
  end

  // Bit capture: a bit counts as delivered when it is valid and the strobe
  // will advance it on the coming edge. First delivered bit ends up highest.
  logic [31:0] capM, capL;
  int          capN;

  always @(negedge clk) begin
    if (!rst && bitEn && xvM) begin
      capM = {capM[30:0], xM};
      capN++;
    end
    if (!rst && bitEn && xvL) capL = {capL[30:0], xL};
  end

  task automatic clearCapture();
    capM = '0;
    capL = '0;
    capN = 0;
  endtask

  function automatic int count1011(input logic [31:0] s, input int n);
    int c;
    c = 0;
    for (int i = 0; i + 4 <= n; i++) begin
      if (s[n-1-i] && !s[n-2-i] && s[n-3-i] && s[n-4-i]) c++;
    end
    return c;
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until the handshake completes (bounded).
  task automatic sendWord(input logic [W-1:0] d);
    bit acc;
    acc       = 1'b0;
    loadValid = 1'b1;
    loadData  = d;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = readyM;
      @(posedge clk);
      #1;
    end
    loadValid = 1'b0;
    if (!acc) begin
      miscompares++;
      vectors++;
      $display("[TB] FAIL send_timeout: word %0h never accepted", d);
    end
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = !busyM && !busyL;
    end
    if (!done) begin
      miscompares++;
      vectors++;
      $display("[TB] FAIL idle_timeout: busy still high");
    end
    @(posedge clk);
    #1;
  endtask

  // Randomized phase: random words, strobe density and occasional resets.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      loadValid = $urandom_range(0, 1);
      loadData  = W'($urandom);
      bitEn     = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    loadValid = 1'b0;
    bitEn     = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    checkEn     = 1'b0;
    rst         = 1'b1;
    loadValid   = 1'b0;
    loadData    = '0;
    bitEn       = 1'b0;
    clearCapture();

    // Reset held for two cycles, then released with no traffic.
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_x",          {31'd0, xM},     32'd0);
    checkOutput("rst_x_valid",    {31'd0, xvM},    32'd0);
    checkOutput("rst_word_done",  {31'd0, doneM},  32'd0);
    checkOutput("rst_busy",       {31'd0, busyM},  32'd0);
    checkOutput("rst_load_ready", {31'd0, readyM}, 32'd1);
    rst = 1'b0;
    idleCycles(5);
    @(negedge clk);
    checkOutput("post_rst_x_valid",    {31'd0, xvM},    32'd0);
    checkOutput("post_rst_load_ready", {31'd0, readyM}, 32'd1);
    @(posedge clk);
    #1;

    // Single word B4 with a continuous strobe.
    bitEn = 1'b1;
    clearCapture();
    sendWord(8'hB4);
    waitIdle();
    checkOutput("b4_bits",      capN,               32'd8);
    checkOutput("b4_msb_order", capM,               32'h0000_00B4);
    checkOutput("b4_lsb_order", capL,               32'h0000_002D);
    checkOutput("b4_detect",    count1011(capM, 8), 32'd1);

    // Back-to-back words: the second parks in the holding register.
    clearCapture();
    sendWord(8'h05);
    sendWord(8'h6F);
    @(negedge clk);
    checkOutput("b2b_ready_low", {31'd0, readyM}, 32'd0);
    waitIdle();
    checkOutput("b2b_bits",   capN,                32'd16);
    checkOutput("b2b_stream", capM,                32'h0000_056F);
    checkOutput("b2b_detect", count1011(capM, 16), 32'd2);

    // Stalled strobe: each bit holds while bit_en is low.
    bitEn = 1'b0;
    clearCapture();
    sendWord(8'hFF);
    for (int k = 0; k < 40; k++) begin
      bitEn = (k % 3 == 0);
      @(posedge clk);
      #1;
    end
    bitEn = 1'b1;
    waitIdle();
    checkOutput("stall_advances", capN, 32'd8);
    checkOutput("stall_stream",   capM, 32'h0000_00FF);

    // LSB-first order on 0D.
    clearCapture();
    sendWord(8'h0D);
    waitIdle();
    checkOutput("lsb_0d_stream", capL, 32'h0000_00B0);
    checkOutput("msb_0d_stream", capM, 32'h0000_000D);

    // Reset on the third bit with a word held.
    sendWord(8'hA5);
    sendWord(8'h3C);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mid_hold_full", {31'd0, readyM}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearCapture();
    @(negedge clk);
    checkOutput("mid_rst_x_valid",    {31'd0, xvM},    32'd0);
    checkOutput("mid_rst_busy",       {31'd0, busyM},  32'd0);
    checkOutput("mid_rst_load_ready", {31'd0, readyM}, 32'd1);
    idleCycles(20);
    checkOutput("mid_rst_no_bits", capN, 32'd0);

    // Randomized traffic against the model.
    applyStimulus(3000);
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
